// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP issue constants, state type and opcode legality helper
package fpu_pkg;

    localparam int N = 32;
    localparam int L = 4;

    localparam logic [5:0] ITOF = 6'h33;
    localparam logic [5:0] FTOI = 6'h34;
    localparam logic [5:0] FADD = 6'h35;
    localparam logic [5:0] FSUB = 6'h36;
    localparam logic [5:0] FNEG = 6'h39;

    localparam int LAT_ITOF = 6;
    localparam int LAT_FTOI = 6;
    localparam int LAT_FADD = 15;
    localparam int LAT_FSUB = 15;
    localparam int LAT_FNEG = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ABORT = 2'd2,
        GAP   = 2'd3
    } issue_state_t;

    function automatic logic is_legal_fp_op(input logic [5:0] op);
        return (op == ITOF) || (op == FTOI) || (op == FADD) ||
               (op == FSUB) || (op == FNEG);
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - decode request, FPU operand and writeback response signal bundle
interface fpu_issue_ctrl_if #(
    parameter int N     = fpu_pkg::N,
    parameter int L     = fpu_pkg::L,
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_opcode;
    logic [N*L-1:0]   req_a;
    logic [N*L-1:0]   req_b;
    logic [TAG_W-1:0] req_tag;

    logic             fpu_ivalid;
    logic [5:0]       fpu_opcode;
    logic [N*L-1:0]   fpu_a;
    logic [N*L-1:0]   fpu_b;
    logic             fpu_stall;
    logic [N*L-1:0]   fpu_o;
    logic             fpu_finish;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [N*L-1:0]   rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    logic             busy;

    modport master (
        input  req_valid, req_opcode, req_a, req_b, req_tag,
        input  fpu_o, fpu_finish, rsp_ready,
        output req_ready, fpu_ivalid, fpu_opcode, fpu_a, fpu_b, fpu_stall,
        output rsp_valid, rsp_data, rsp_tag, rsp_err, busy
    );

    modport slave (
        output req_valid, req_opcode, req_a, req_b, req_tag,
        output fpu_o, fpu_finish, rsp_ready,
        input  req_ready, fpu_ivalid, fpu_opcode, fpu_a, fpu_b, fpu_stall,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err, busy
    );

endinterface

// File: rtl/fpu_rsp_buffer.sv
// rtl/fpu_rsp_buffer.sv - one-entry response register holding {data, tag, err}
module fpu_rsp_buffer #(
    parameter int DATA_W = 128,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic              push_err,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag,
    output logic              err
);

    // A push in the same cycle as a pop replaces the entry and keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
            tag  <= '0;
            err  <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
            tag  <= push_tag;
            err  <= push_err;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - single-outstanding FP request issue controller with watchdog and response buffer
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63,
    parameter int WD_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    fpu_issue_ctrl_if.master io
);

    issue_state_t     state;
    issue_state_t     state_nxt;
    logic [5:0]       op_q;
    logic [N*L-1:0]   a_q;
    logic [N*L-1:0]   b_q;
    logic [TAG_W-1:0] tag_q;
    logic [WD_W-1:0]  wd_q;

    logic             accept;
    logic             buf_free;
    logic             buf_full;
    logic             push;
    logic [N*L-1:0]   push_data;
    logic             push_err;
    logic [N*L-1:0]   buf_data;
    logic [TAG_W-1:0] buf_tag;
    logic             buf_err;
    logic             wd_expired;

    assign accept     = io.req_valid && io.req_ready;
    assign buf_free   = !buf_full || io.rsp_ready;
    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op_q  <= io.req_opcode;
            a_q   <= io.req_a;
            b_q   <= io.req_b;
            tag_q <= io.req_tag;
        end
    end

    // The watchdog only counts cycles waiting for finish; a stalled finish freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (accept) begin
            wd_q <= '0;
        end else if (state == ISSUE && !io.fpu_finish) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_legal_fp_op(io.req_opcode) ? ISSUE : ABORT;
                end
            end
            ISSUE: begin
                if (io.fpu_finish) begin
                    if (buf_free) begin
                        state_nxt = GAP;
                    end
                end else if (wd_expired) begin
                    state_nxt = ABORT;
                end
            end
            ABORT: begin
                if (buf_free) begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        io.req_ready  = rst_n && (state == IDLE);
        io.fpu_ivalid = (state == ISSUE);
        io.fpu_stall  = (state == ISSUE) && io.fpu_finish && !buf_free;
        push          = 1'b0;
        push_data     = '0;
        push_err      = 1'b0;
        if (state == ISSUE && io.fpu_finish && buf_free) begin
            push      = 1'b1;
            push_data = io.fpu_o;
        end else if (state == ABORT && buf_free) begin
            push      = 1'b1;
            push_err  = 1'b1;
        end
    end

    assign io.fpu_opcode = op_q;
    assign io.fpu_a      = a_q;
    assign io.fpu_b      = b_q;

    fpu_rsp_buffer #(
        .DATA_W (N * L),
        .TAG_W  (TAG_W)
    ) u_rsp_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (io.rsp_ready),
        .push_data (push_data),
        .push_tag  (tag_q),
        .push_err  (push_err),
        .full      (buf_full),
        .data      (buf_data),
        .tag       (buf_tag),
        .err       (buf_err)
    );

    assign io.rsp_valid = buf_full;
    assign io.rsp_data  = buf_data;
    assign io.rsp_tag   = buf_tag;
    assign io.rsp_err   = buf_err;
    assign io.busy      = (state != IDLE) || buf_full;

endmodule
